// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity convention common to
// the TX and RX paths, and the supported oversampling ratios.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_ODD  = 1'b1;
    localparam logic PAR_EVEN = 1'b0;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point majority sampler around the middle of each bit period.
// The voted bit is registered and becomes valid at edge_cnt = P/2+2.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  rx_in,
    output logic                  sampled_bit
);

    logic [1:0]            samp_q, samp_d;
    logic                  vote_q, vote_d;
    logic [PRESCALE_W-1:0] mid;

    always_comb begin
        mid    = prescale >> 1;
        samp_d = samp_q;
        vote_d = vote_q;
        if (edge_cnt == mid - PRESCALE_W'(1)) begin
            samp_d[0] = rx_in;
        end
        if (edge_cnt == mid) begin
            samp_d[1] = rx_in;
        end
        // Third sample feeds the vote directly, so the result lands one tick later.
        if (edge_cnt == mid + PRESCALE_W'(1)) begin
            vote_d = maj3(samp_q[0], samp_q[1], rx_in);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp_q <= 2'b00;
            vote_q <= 1'b0;
        end else begin
            samp_q <= samp_d;
            vote_q <= vote_d;
        end
    end

    assign sampled_bit = vote_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive core: start detection, LSB-first deserialization, optional
// parity check and stop check, with one-cycle result pulses.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_flag_q, par_flag_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic                  sampled_bit;
    logic                  at_vote;
    logic                  at_wrap;
    logic                  exp_par;

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .edge_cnt    (edge_cnt_q),
        .prescale    (prescale_q),
        .rx_in       (RX_IN),
        .sampled_bit (sampled_bit)
    );

    assign at_vote = (edge_cnt_q == (prescale_q >> 1) + PRESCALE_W'(2));
    assign at_wrap = (edge_cnt_q == prescale_q - PRESCALE_W'(1));
    assign exp_par = (^shift_q) ^ (par_typ_q == PAR_ODD);

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_flag_d   = par_flag_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        if (state_q != IDLE) begin
            edge_cnt_d = at_wrap ? '0 : edge_cnt_q + PRESCALE_W'(1);
        end

        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!RX_IN) begin
                    state_d    = START;
                    prescale_d = Prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_flag_d = 1'b0;
                    shift_d    = '0;
                end
            end
            START: begin
                if (at_vote && sampled_bit) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                end else if (at_wrap) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (at_vote) begin
                    shift_d[bit_cnt_q] = sampled_bit;
                end
                if (at_wrap) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (at_vote && (sampled_bit != exp_par)) begin
                    par_flag_d = 1'b1;
                end
                if (at_wrap) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Leave half a bit early so the next start edge is never missed.
                if (at_vote) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                    stp_err_d  = !sampled_bit;
                    par_err_d  = par_flag_q;
                    if (sampled_bit && !par_flag_q) begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            prescale_q   <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_flag_q   <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_flag_q   <= par_flag_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed frame-level bench for uart_rx_frame; a per-cycle compare process
// checks every output against expectations scheduled from whole-frame rules.
module tb_uart_rx_frame;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [PW-1:0] Prescale;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          busy;

    uart_rx_frame #(
        .DATA_WIDTH (DW),
        .PRESCALE_W (PW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    // cyc labels posedges; at a negedge it names the posedge just taken.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    bit            exp_busy[int];
    logic [2:0]    exp_ev[int];     // {data_valid, par_err, stp_err}
    logic [DW-1:0] exp_load[int];
    logic [DW-1:0] model_pdata = '0;

    int dv_cnt = 0;
    int pe_cnt = 0;
    int se_cnt = 0;
    int last_dv_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    always @(negedge CLK) begin
        logic [2:0] ev;
        logic       bexp;
        ev   = 3'b000;
        bexp = 1'b0;
        if (RST) begin
            if (exp_ev.exists(cyc)) ev = exp_ev[cyc];
            bexp = exp_busy.exists(cyc);
            if (ev[2]) model_pdata = exp_load[cyc];
        end else begin
            model_pdata = '0;
        end
        chk("data_valid", 32'(data_valid), 32'(ev[2]));
        chk("par_err",    32'(par_err),    32'(ev[1]));
        chk("stp_err",    32'(stp_err),    32'(ev[0]));
        chk("busy",       32'(busy),       32'(bexp));
        chk("P_DATA",     32'(P_DATA),     32'(model_pdata));
        if (data_valid === 1'b1) begin
            dv_cnt++;
            last_dv_cyc = cyc;
        end
        if (par_err === 1'b1) pe_cnt++;
        if (stp_err === 1'b1) se_cnt++;
    end

    task automatic drive_bit(input logic v, input int n);
        RX_IN = v;
        repeat (n) @(negedge CLK);
    endtask

    // Schedules the frame's outcome from frame-level rules, then drives it.
    // s returns the cycle at which the stop bit is first seen by the receiver.
    task automatic send_frame(input logic [DW-1:0] d, input int p, input bit pen,
                              input bit ptyp, input bit pbit, input bit stp,
                              input int gap, input bit perturb, output int s);
        int e;
        int t;
        bit perr;
        bit serr;
        Prescale = PW'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        e = cyc + 1;
        s = e + (1 + DW + (pen ? 1 : 0)) * p;
        t = s + p / 2 + 3;
        for (int i = e; i < t; i++) exp_busy[i] = 1'b1;
        perr = pen && (pbit != ((^d) ^ ptyp));
        serr = !stp;
        exp_ev[t]   = {!perr && !serr, perr, serr};
        exp_load[t] = d;
        // A low stop bit is still low when the receiver is back in IDLE: it
        // starts again, and that start is rejected once the line is high.
        if (!stp && p >= 10) begin
            for (int i = t + 1; i <= t + 1 + p / 2 + 2; i++) exp_busy[i] = 1'b1;
        end
        RX_IN = 1'b0;
        @(negedge CLK);
        if (perturb) begin
            Prescale = PW'(16);
            PAR_EN   = !pen;
            PAR_TYP  = !ptyp;
        end
        repeat (p - 1) @(negedge CLK);
        for (int i = 0; i < DW; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(stp, p);
        Prescale = PW'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        drive_bit(1'b1, gap);
    endtask

    initial begin
        int s;
        int s2;
        int e;
        logic [DW-1:0] d55;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        Prescale = PW'(8);
        RST      = 1'b1;
        #1 RST   = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_P_DATA", 32'(P_DATA), 32'h0);
        chk("reset_busy",   32'(busy),   32'h0);
        #2 RST = 1'b1;
        drive_bit(1'b1, 4);

        // Good frame, even parity.
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 8, 1'b0, s);
        chk("t1_P_DATA", 32'(P_DATA), 32'hA5);
        chk("t1_dv_cnt", 32'(dv_cnt), 32'd1);

        // Odd parity expected, even parity sent.
        send_frame(8'hA5, 16, 1'b1, 1'b1, 1'b0, 1'b1, 16, 1'b0, s);
        chk("t2_P_DATA", 32'(P_DATA), 32'hA5);
        chk("t2_pe_cnt", 32'(pe_cnt), 32'd1);
        chk("t2_dv_cnt", 32'(dv_cnt), 32'd1);

        // Stop bit low, then a good frame.
        send_frame(8'h3C, 32, 1'b0, 1'b0, 1'b0, 1'b0, 40, 1'b0, s);
        chk("t3_se_cnt", 32'(se_cnt), 32'd1);
        chk("t3_pe_cnt", 32'(pe_cnt), 32'd1);
        chk("t3_P_DATA_hold", 32'(P_DATA), 32'hA5);
        send_frame(8'h3C, 32, 1'b0, 1'b0, 1'b0, 1'b1, 32, 1'b0, s);
        chk("t3_P_DATA", 32'(P_DATA), 32'h3C);
        chk("t3_dv_cnt", 32'(dv_cnt), 32'd2);

        // Two-tick glitch, then a frame whose config inputs change mid-frame.
        Prescale = PW'(8);
        e = cyc + 1;
        for (int i = e; i <= e + 8 / 2 + 2; i++) exp_busy[i] = 1'b1;
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 16);
        chk("t4_dv_cnt", 32'(dv_cnt), 32'd2);
        chk("t4_se_cnt", 32'(se_cnt), 32'd1);
        send_frame(8'h96, 8, 1'b1, 1'b0, 1'b0, 1'b1, 8, 1'b1, s);
        chk("t4_P_DATA", 32'(P_DATA), 32'h96);
        chk("t4_pe_cnt", 32'(pe_cnt), 32'd1);

        // Back-to-back frames, no idle beyond the stop bit.
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, s);
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0, s2);
        chk("t5_dv_cnt",  32'(dv_cnt), 32'd5);
        chk("t5_P_DATA",  32'(P_DATA), 32'hFF);
        chk("t5_latency", 32'(last_dv_cyc - s2), 32'd7);

        // Reset during data bit 4 of 0x55.
        d55 = 8'h55;
        Prescale = PW'(8);
        PAR_EN   = 1'b0;
        e = cyc + 1;
        for (int i = e; i <= e + 42; i++) exp_busy[i] = 1'b1;
        drive_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(d55[i], 8);
        drive_bit(d55[4], 3);
        #2 RST = 1'b0;
        exp_busy.delete();
        exp_ev.delete();
        exp_load.delete();
        RX_IN = 1'b1;
        @(negedge CLK);
        chk("t6_rst_busy",   32'(busy),       32'h0);
        chk("t6_rst_P_DATA", 32'(P_DATA),     32'h0);
        chk("t6_rst_dv",     32'(data_valid), 32'h0);
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        drive_bit(1'b1, 8);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0, s);
        chk("t6_P_DATA", 32'(P_DATA), 32'h55);
        chk("t6_dv_cnt", 32'(dv_cnt), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
